// File: rtl/pc_seq_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and constants for the fetch-side PC sequencer.
//   seq_state_t    : sequencer state (BOOT, FETCH, HALTED)
//   redirect_src_t : where the next PC comes from (sequential, branch, trap)
//   INSTR_BYTES    : size of one instruction, i.e. the sequential PC step
//   is_misaligned  : true when a redirect target is not word aligned
// ----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HALTED
    } seq_state_t;

    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_BRANCH,
        SRC_TRAP
    } redirect_src_t;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// ----------------------------------------------------------------------------
// pc_redirect_buf
// One-entry buffer holding a redirect that arrived while it could not be
// applied (fetch outstanding, or core halted).
//   i_clk, i_rst      : clock, synchronous active-high reset (clears entry)
//   i_consume         : entry is being applied this cycle, drop it
//   i_capture         : new redirect requests may be recorded this cycle
//   i_trap            : trap request (target is TRAP_VEC)
//   i_branch          : branch/jump request with i_branch_target
//   o_valid/o_is_trap/o_target : current entry
// A trap overwrites whatever is held; a branch is recorded only when the
// entry is empty or holds another branch, so a trap is never lost to a
// younger branch.
// ----------------------------------------------------------------------------
module pc_redirect_buf
    import pc_seq_pkg::*;
#(
    parameter int unsigned        DWIDTH   = 32,
    parameter logic [DWIDTH-1:0]  TRAP_VEC = 32'h0000_0100
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_consume,
    input  logic              i_capture,
    input  logic              i_trap,
    input  logic              i_branch,
    input  logic [DWIDTH-1:0] i_branch_target,
    output logic              o_valid,
    output logic              o_is_trap,
    output logic [DWIDTH-1:0] o_target
);

    logic              r_valid;
    logic              r_is_trap;
    logic [DWIDTH-1:0] r_target;

    // Entry as seen by the merge: an entry consumed this cycle counts as empty.
    logic w_base_valid;
    logic w_take_trap;
    logic w_take_branch;

    assign w_base_valid  = r_valid & ~i_consume;
    assign w_take_trap   = i_capture & i_trap;
    assign w_take_branch = i_capture & i_branch & ~(w_base_valid & r_is_trap);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_is_trap <= 1'b0;
        end else if (w_take_trap) begin
            r_valid   <= 1'b1;
            r_is_trap <= 1'b1;
        end else if (w_take_branch) begin
            r_valid   <= 1'b1;
            r_is_trap <= 1'b0;
        end else if (i_consume) begin
            r_valid   <= 1'b0;
        end
    end

    // NOTE: the target is a data register qualified by r_valid, so it needs
    // no reset; only the valid flag must be cleared.
    always_ff @(posedge i_clk) begin
        if (w_take_trap) begin
            r_target <= TRAP_VEC;
        end else if (w_take_branch) begin
            r_target <= i_branch_target;
        end
    end

    assign o_valid   = r_valid;
    assign o_is_trap = r_is_trap;
    assign o_target  = r_target;

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Fetch-side controller for the program_counter register: chooses the next
// PC (boot vector, trap, branch redirect or PC+4), runs the imem request
// handshake and supports halt/resume.
//   Clk_Core, Rst_Core : core clock, synchronous active-high reset
//   Program_Count      : current PC from the PC register (fetch address)
//   Stall              : hazard stall, blocks the sequential advance only
//   Branch_Taken/Branch_Target : EX redirect
//   Trap_Req           : trap redirect to TRAP_VEC
//   Halt_Req / Resume  : enter / leave HALTED
//   Fetch_Ack          : imem accepted the request this cycle
//   Fetch_Req          : imem request, address = Program_Count
//   Run / Program_Count_New : PC register load enable and next value
//   Flush              : kill IF/ID contents this cycle
//   Halted             : core halted
//   Misalign_Fault     : misaligned redirect replaced by TRAP_VEC
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned        DWIDTH    = 32,
    parameter logic [DWIDTH-1:0]  RESET_VEC = 32'h0000_0000,
    parameter logic [DWIDTH-1:0]  TRAP_VEC  = 32'h0000_0100
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic [DWIDTH-1:0] Program_Count,
    input  logic              Stall,
    input  logic              Branch_Taken,
    input  logic [DWIDTH-1:0] Branch_Target,
    input  logic              Trap_Req,
    input  logic              Halt_Req,
    input  logic              Resume,
    input  logic              Fetch_Ack,
    output logic              Fetch_Req,
    output logic              Run,
    output logic [DWIDTH-1:0] Program_Count_New,
    output logic              Flush,
    output logic              Halted,
    output logic              Misalign_Fault
);

    seq_state_t r_state;

    logic              w_pend_valid;
    logic              w_pend_is_trap;
    logic [DWIDTH-1:0] w_pend_target;
    logic [DWIDTH-1:0] w_pc_plus4;

    logic              w_run;
    logic              w_flush;
    logic              w_misalign;
    logic              w_consume;
    logic              w_capture;
    logic [DWIDTH-1:0] w_pcn;
    logic [DWIDTH-1:0] w_target;
    redirect_src_t     w_src;

    // Wraps modulo 2^DWIDTH by construction.
    assign w_pc_plus4 = Program_Count + DWIDTH'(INSTR_BYTES);

    pc_redirect_buf #(
        .DWIDTH   (DWIDTH),
        .TRAP_VEC (TRAP_VEC)
    ) u_redirect_buf (
        .i_clk           (Clk_Core),
        .i_rst           (Rst_Core),
        .i_consume       (w_consume),
        .i_capture       (w_capture),
        .i_trap          (Trap_Req),
        .i_branch        (Branch_Taken),
        .i_branch_target (Branch_Target),
        .o_valid         (w_pend_valid),
        .o_is_trap       (w_pend_is_trap),
        .o_target        (w_pend_target)
    );

    // Next-PC selection. Requests are captured in every cycle except an
    // acked fetch, where they are considered directly by the priority chain.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        w_run      = 1'b0;
        w_flush    = 1'b0;
        w_misalign = 1'b0;
        w_pcn      = Program_Count;
        w_target   = Program_Count;
        w_src      = SRC_SEQ;
        w_consume  = 1'b0;
        w_capture  = ~Rst_Core;

        if (Rst_Core) begin
            w_pcn = RESET_VEC;
        end else begin
            case (r_state)
                BOOT: begin
                    w_run   = 1'b1;
                    w_flush = 1'b1;
                    w_pcn   = RESET_VEC;
                end
                FETCH: begin
                    if (Fetch_Ack) begin
                        w_capture = 1'b0;
                        w_consume = 1'b1;
                        if (Trap_Req) begin
                            w_src    = SRC_TRAP;
                            w_target = TRAP_VEC;
                        end else if (w_pend_valid) begin
                            w_src    = w_pend_is_trap ? SRC_TRAP : SRC_BRANCH;
                            w_target = w_pend_target;
                        end else if (Branch_Taken) begin
                            w_src    = SRC_BRANCH;
                            w_target = Branch_Target;
                        end else if (!Stall) begin
                            w_run = 1'b1;
                            w_pcn = w_pc_plus4;
                        end
                    end
                end
                HALTED: begin
                    if (Resume) begin
                        w_run = 1'b1;
                        if (w_pend_valid) begin
                            w_consume = 1'b1;
                            w_src     = w_pend_is_trap ? SRC_TRAP : SRC_BRANCH;
                            w_target  = w_pend_target;
                        end
                    end
                end
                default: ;
            endcase

            if (w_src != SRC_SEQ) begin
                w_run   = 1'b1;
                w_flush = 1'b1;
                if (is_misaligned(w_target[1:0])) begin
                    w_pcn      = TRAP_VEC;
                    w_misalign = 1'b1;
                end else begin
                    w_pcn = w_target;
                end
            end
        end
    end

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            r_state <= BOOT;
        end else begin
            case (r_state)
                BOOT:    r_state <= FETCH;
                FETCH:   if (Fetch_Ack && Halt_Req) r_state <= HALTED;
                HALTED:  if (Resume) r_state <= FETCH;
                default: r_state <= BOOT;
            endcase
        end
    end

    // Reset is synchronous, so the state decodes are masked while it is held.
    assign Fetch_Req         = (r_state == FETCH)  & ~Rst_Core;
    assign Halted            = (r_state == HALTED) & ~Rst_Core;
    assign Run               = w_run;
    assign Flush             = w_flush;
    assign Program_Count_New = w_pcn;
    assign Misalign_Fault    = w_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RST_V  = 32'h0000_1000;
    localparam logic [31:0] TRAP_V = 32'h0000_0100;

    typedef logic [36:0] obs_t;   // {Fetch_Req, Run, Flush, Halted, Misalign_Fault, PCN}
    typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        stall, br, trap, halt, resume, ack;
    logic [31:0] br_tgt;
    logic        fetch_req, run, flush, halted, mis;
    logic [31:0] pcn;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: mode, pending redirect, and next-cycle copies.
    mode_t       m_mode = M_BOOT, nx_mode;
    bit          m_pv = 0, m_pt = 0, nx_pv, nx_pt;
    logic [31:0] m_pa = '0, nx_pa;

    pc_sequencer #(
        .DWIDTH    (32),
        .RESET_VEC (RST_V),
        .TRAP_VEC  (TRAP_V)
    ) dut (
        .Clk_Core          (clk),
        .Rst_Core          (rst),
        .Program_Count     (pc),
        .Stall             (stall),
        .Branch_Taken      (br),
        .Branch_Target     (br_tgt),
        .Trap_Req          (trap),
        .Halt_Req          (halt),
        .Resume            (resume),
        .Fetch_Ack         (ack),
        .Fetch_Req         (fetch_req),
        .Run               (run),
        .Program_Count_New (pcn),
        .Flush             (flush),
        .Halted            (halted),
        .Misalign_Fault    (mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t pack(bit f, bit r, bit fl, bit h, bit m, logic [31:0] a);
        return {f, r, fl, h, m, a};
    endfunction

    function automatic obs_t outs();
        return {fetch_req, run, flush, halted, mis, pcn};
    endfunction

    function automatic logic [4:0] ctl();
        return {fetch_req, run, flush, halted, mis};
    endfunction

    // Behavioural model: expected outputs for the current inputs plus the
    // next mode / pending entry, from the sequencer's rules.
    task automatic eval(output obs_t e);
        bit f = 0, r = 0, fl = 0, h = 0, m = 0, redir = 0, cap = 1;
        logic [31:0] a = pc, tgt = '0;
        nx_mode = m_mode; nx_pv = m_pv; nx_pt = m_pt; nx_pa = m_pa;
        if (rst) begin
            a = RST_V; nx_mode = M_BOOT; nx_pv = 0;
        end else begin
            case (m_mode)
                M_BOOT: begin r = 1; fl = 1; a = RST_V; nx_mode = M_RUN; end
                M_RUN: begin
                    f = 1;
                    if (ack) begin
                        cap = 0; nx_pv = 0;
                        if (trap)        begin redir = 1; tgt = TRAP_V; end
                        else if (m_pv)   begin redir = 1; tgt = m_pa; end
                        else if (br)     begin redir = 1; tgt = br_tgt; end
                        else if (!stall) begin r = 1; a = pc + 32'd4; end
                        if (halt) nx_mode = M_HALT;
                    end
                end
                M_HALT: begin
                    h = 1;
                    if (resume) begin
                        r = 1; nx_mode = M_RUN;
                        if (m_pv) begin redir = 1; tgt = m_pa; nx_pv = 0; end
                    end
                end
            endcase
            if (redir) begin
                r = 1; fl = 1;
                if (tgt % 4 != 0) begin a = TRAP_V; m = 1; end
                else a = tgt;
            end
            if (cap) begin
                if (trap) begin nx_pv = 1; nx_pt = 1; nx_pa = TRAP_V; end
                else if (br && !(nx_pv && nx_pt)) begin nx_pv = 1; nx_pt = 0; nx_pa = br_tgt; end
            end
        end
        e = pack(f, r, fl, h, m, a);
    endtask

    // Advance one clock: commit the model and the bench-side PC register.
    task automatic tick();
        obs_t e;
        eval(e);
        @(posedge clk);
        #1;
        m_mode = nx_mode; m_pv = nx_pv; m_pt = nx_pt; m_pa = nx_pa;
        if (rst)       pc = '0;
        else if (e[35]) pc = e[31:0];
        @(negedge clk);
    endtask

    task automatic set_in(bit a, bit b, logic [31:0] t, bit tr, bit hl, bit rs);
        ack = a; br = b; br_tgt = t; trap = tr; halt = hl; resume = rs;
        #1;
    endtask

    task automatic test_reset();
        obs_t exp;
        rst = 1; stall = 0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, '0, 0, 0, 0);
            exp = pack(0, 0, 0, 0, 0, RST_V);
            n_checks++;
            if (outs() !== exp) begin n_fail++; $display("FAIL reset[%0d]: got %h want %h", i, outs(), exp); end
            tick();
        end
    endtask

    task automatic test_boot();
        obs_t exp;
        rst = 0;
        set_in(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp = (i == 0) ? pack(0, 1, 1, 0, 0, RST_V) : pack(1, 1, 0, 0, 0, RST_V + 32'(4 * i));
            n_checks++;
            if (outs() !== exp) begin n_fail++; $display("FAIL boot[%0d]: got %h want %h", i, outs(), exp); end
            tick();
        end
    endtask

    task automatic test_ack_stall();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, '0, 0, 0, 0);
            n_checks++;
            if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL ack_low[%0d]: ctl got %b want 10000", i, ctl()); end
            tick();
        end
        n_checks++;
        if (pc !== 32'h1008) begin n_fail++; $display("FAIL ack_low_pc: got %h want 00001008", pc); end
    endtask

    task automatic test_pending_branch();
        obs_t exp;
        set_in(0, 1, 32'h2000, 0, 0, 0); tick();
        set_in(0, 0, '0, 0, 0, 0);
        n_checks++;
        if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL pend_br_wait: ctl got %b want 10000", ctl()); end
        tick();
        set_in(1, 0, '0, 0, 0, 0);
        exp = pack(1, 1, 1, 0, 0, 32'h2000);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL pend_br_ack: got %h want %h", outs(), exp); end
        tick();
    endtask

    task automatic test_pending_trap();
        obs_t exp;
        set_in(0, 1, 32'h2000, 0, 0, 0); tick();
        set_in(0, 0, '0, 1, 0, 0); tick();
        set_in(1, 0, '0, 0, 0, 0);
        exp = pack(1, 1, 1, 0, 0, TRAP_V);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL pend_trap_ack: got %h want %h", outs(), exp); end
        tick();
        exp = pack(1, 1, 0, 0, 0, TRAP_V + 32'd4);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL pend_cleared: got %h want %h", outs(), exp); end
        tick();
    endtask

    task automatic test_misalign();
        obs_t exp;
        set_in(1, 1, 32'h2002, 0, 0, 0);
        exp = pack(1, 1, 1, 0, 1, TRAP_V);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL misalign: got %h want %h", outs(), exp); end
        tick();
        set_in(1, 0, '0, 0, 0, 0);
        exp = pack(1, 1, 0, 0, 0, TRAP_V + 32'd4);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL misalign_pulse: got %h want %h", outs(), exp); end
        tick();
    endtask

    task automatic test_halt_resume();
        obs_t exp;
        set_in(1, 1, 32'h1010, 0, 0, 0); tick();
        set_in(1, 0, '0, 0, 1, 0);
        exp = pack(1, 1, 0, 0, 0, 32'h1014);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL halt_ack: got %h want %h", outs(), exp); end
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, '0, 0, 0, 0);
            n_checks++;
            if (ctl() !== 5'b00010) begin n_fail++; $display("FAIL halted[%0d]: ctl got %b want 00010", i, ctl()); end
            tick();
        end
        set_in(1, 0, '0, 0, 0, 1);
        exp = pack(0, 1, 0, 1, 0, 32'h1014);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL resume: got %h want %h", outs(), exp); end
        tick();
        set_in(1, 0, '0, 0, 0, 0);
        exp = pack(1, 1, 0, 0, 0, 32'h1018);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL resume_fetch: got %h want %h", outs(), exp); end
        tick();
    endtask

    task automatic test_halt_redirect();
        obs_t exp;
        set_in(1, 0, '0, 0, 1, 0); tick();
        set_in(1, 1, 32'h3000, 0, 0, 0); tick();
        set_in(1, 0, '0, 0, 0, 1);
        exp = pack(0, 1, 1, 1, 0, 32'h3000);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL halt_redirect: got %h want %h", outs(), exp); end
        tick();
    endtask

    task automatic test_wrap();
        obs_t exp;
        set_in(1, 1, 32'hFFFF_FFFC, 0, 0, 0); tick();
        set_in(1, 0, '0, 0, 0, 0);
        exp = pack(1, 1, 0, 0, 0, 32'h0);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL wrap: got %h want %h", outs(), exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        obs_t exp;
        set_in(0, 1, 32'h5000, 0, 0, 0); tick();
        rst = 1;
        set_in(1, 0, '0, 0, 0, 0);
        exp = pack(0, 0, 0, 0, 0, RST_V);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL reset_mid: got %h want %h", outs(), exp); end
        tick();
        rst = 0; #1; tick();
        exp = pack(1, 1, 0, 0, 0, RST_V + 32'd4);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL reset_mid_pend: got %h want %h", outs(), exp); end
        tick();
    endtask

    task automatic test_random();
        obs_t exp;
        logic [31:0] t;
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 4) == 0);
            t = $urandom;
            if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
            set_in($urandom_range(0, 9) < 6, $urandom_range(0, 6) == 0, t,
                   $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 4) == 0);
            eval(exp);
            n_checks++;
            if (ctl() !== exp[36:32]) begin
                n_fail++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, ctl(), exp[36:32]);
            end
            if (exp[35]) begin
                n_checks++;
                if (pcn !== exp[31:0]) begin
                    n_fail++; $display("FAIL rand_pcn[%0d]: got %h want %h", i, pcn, exp[31:0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1; pc = '0; stall = 0; br = 0; br_tgt = '0;
        trap = 0; halt = 0; resume = 0; ack = 0;
        @(negedge clk);
        test_reset();
        test_boot();
        test_ack_stall();
        test_pending_branch();
        test_pending_trap();
        test_misalign();
        test_halt_resume();
        test_halt_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
